// File: rtl/jpeg_bit_packer.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_bit_packer
// Purpose  : Packs Huffman code + magnitude fields MSB-first into bytes, pads
//            with 1s on flush; 0x00 stuffing after 0xFF when JPEG_BYTE_STUFF_EN.
// Revision : 1.0
// ============================================================================
module jpeg_bit_packer #(
    parameter int BUF_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] huff_code,
    input  logic [3:0]  huff_len,
    input  logic [7:0]  val_bits,
    input  logic [3:0]  val_len,
    input  logic        flush,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        flush_done,
    output logic [15:0] byte_count
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_PAD   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
`ifdef JPEG_BYTE_STUFF_EN
    localparam logic [1:0] S_STUFF = 2'd3;
`endif
    localparam logic [4:0] C_BYTE  = 5'd8;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [BUF_W-1:0] r_buf;
    logic [4:0]       r_bit_cnt;
    logic             r_flush_pend;

    logic [3:0]       w_vlen;
    logic [15:0]      w_code;
    logic [7:0]       w_val;
    logic [BUF_W-1:0] w_sym;
    logic [4:0]       w_tot;
    logic [5:0]       w_shift;
    logic [7:0]       w_top;
    logic             w_accept;
    logic             w_data_valid;
    logic             w_pop;
    logic             w_pop_ff;
    logic             w_stuff_take;
    logic             w_stuff_done;
    logic             w_byte_inc;
    logic             w_done;

    // Symbol formatting: mask unused bits, concatenate code then magnitude
    assign w_vlen  = (val_len > 4'd8) ? 4'd8 : val_len;
    assign w_code  = huff_code & (16'h7FFF >> (4'd15 - huff_len));
    assign w_val   = val_bits & (8'hFF >> (4'd8 - w_vlen));
    assign w_sym   = (BUF_W'(w_code) << w_vlen) | BUF_W'(w_val);
    assign w_tot   = {1'b0, huff_len} + {1'b0, w_vlen};
    assign w_shift = 6'(BUF_W) - {1'b0, r_bit_cnt} - {1'b0, w_tot};
    assign w_top   = r_buf[BUF_W-1 -: 8];

    assign w_accept     = in_valid && in_ready;
    assign w_data_valid = ((r_state == S_RUN) || (r_state == S_DRAIN)) && (r_bit_cnt >= C_BYTE);
    assign w_pop        = w_data_valid && out_ready;

`ifdef JPEG_BYTE_STUFF_EN
    logic r_ret_drain;

    assign w_pop_ff     = w_pop && (w_top == 8'hFF);
    assign w_stuff_take = (r_state == S_STUFF) && out_ready;
    assign w_stuff_done = w_stuff_take && r_ret_drain && (r_bit_cnt == 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ret_drain <= 1'b0;
        end else if (w_pop_ff) begin
            r_ret_drain <= (r_state == S_DRAIN);
        end
    end
`else
    assign w_pop_ff     = 1'b0;
    assign w_stuff_take = 1'b0;
    assign w_stuff_done = 1'b0;
`endif

    assign w_byte_inc = w_pop || w_stuff_take;

    // Flush completes on the last drain pop; an empty pad finishes straight away
    assign w_done = ((r_state == S_PAD) && (r_bit_cnt == 5'd0))
                 || ((r_state == S_DRAIN) && ((r_bit_cnt == 5'd0)
                     || (w_pop && (r_bit_cnt == C_BYTE) && !w_pop_ff)))
                 || w_stuff_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
`ifdef JPEG_BYTE_STUFF_EN
                if (w_pop_ff) begin
                    w_state_nxt = S_STUFF;
                end else
`endif
                if ((r_flush_pend || flush) && (r_bit_cnt < C_BYTE) && !w_accept) begin
                    w_state_nxt = S_PAD;
                end
            end
            S_PAD: begin
                w_state_nxt = (r_bit_cnt == 5'd0) ? S_RUN : S_DRAIN;
            end
            S_DRAIN: begin
`ifdef JPEG_BYTE_STUFF_EN
                if (w_pop_ff) begin
                    w_state_nxt = S_STUFF;
                end else
`endif
                if (w_done) begin
                    w_state_nxt = S_RUN;
                end
            end
`ifdef JPEG_BYTE_STUFF_EN
            S_STUFF: begin
                if (out_ready) begin
                    if (r_ret_drain && (r_bit_cnt != 5'd0)) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
`endif
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_RUN) && (r_bit_cnt < C_BYTE) && !r_flush_pend;
        out_valid = w_data_valid;
        out_data  = w_top;
`ifdef JPEG_BYTE_STUFF_EN
        if (r_state == S_STUFF) begin
            out_valid = 1'b1;
            out_data  = 8'h00;
        end
`endif
    end

    // Accept and pop are exclusive: accept needs fewer than 8 bits, pop at least 8
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf        <= '0;
            r_bit_cnt    <= 5'd0;
            r_flush_pend <= 1'b0;
            flush_done   <= 1'b0;
            byte_count   <= 16'd0;
        end else begin
            flush_done <= w_done;
            if (w_done) begin
                r_flush_pend <= 1'b0;
            end else if (flush) begin
                r_flush_pend <= 1'b1;
            end
            if (w_byte_inc) begin
                byte_count <= byte_count + 16'd1;
            end
            if (w_accept) begin
                r_buf     <= r_buf | (w_sym << w_shift);
                r_bit_cnt <= r_bit_cnt + w_tot;
            end else if (w_pop) begin
                r_buf     <= r_buf << 8;
                r_bit_cnt <= r_bit_cnt - C_BYTE;
            end else if ((r_state == S_PAD) && (r_bit_cnt != 5'd0)) begin
                r_buf[BUF_W-1 -: 8] <= w_top | (8'hFF >> r_bit_cnt);
                r_bit_cnt           <= C_BYTE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jpeg_bit_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_jpeg_bit_packer
// Purpose  : Directed and randomized checks of jpeg_bit_packer against a
//            bit-queue reference model.
// Revision : 1.0
// ============================================================================
module tb_jpeg_bit_packer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] huff_code;
    logic [3:0]  huff_len;
    logic [7:0]  val_bits;
    logic [3:0]  val_len;
    logic        flush;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        flush_done;
    logic [15:0] byte_count;

    int          errors = 0;
    int          checks = 0;
    int          fd_cnt = 0;
    bit          rnd_ready = 1'b0;
    logic [7:0]  gotq[$];
    logic [7:0]  expq[$];
    bit          bitq[$];
    int          model_cnt = 0;

    jpeg_bit_packer #(.BUF_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .huff_code  (huff_code),
        .huff_len   (huff_len),
        .val_bits   (val_bits),
        .val_len    (val_len),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .flush_done (flush_done),
        .byte_count (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) gotq.push_back(out_data);
        if (flush_done) fd_cnt++;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] gq(input int i);
        if (i < gotq.size()) return gotq[i];
        return 8'hxx;
    endfunction

    // Reference model: a plain bit queue turned into bytes
    task automatic model_extract();
        while (bitq.size() >= 8) begin
            logic [7:0] b;
            b = 8'h00;
            for (int i = 0; i < 8; i++) b = {b[6:0], bitq.pop_front()};
            expq.push_back(b);
            model_cnt++;
`ifdef JPEG_BYTE_STUFF_EN
            if (b == 8'hFF) begin
                expq.push_back(8'h00);
                model_cnt++;
            end
`endif
        end
    endtask

    task automatic model_push(input logic [15:0] c, input int hl, input logic [7:0] v, input int vl);
        int n;
        n = (vl > 8) ? 8 : vl;
        for (int i = hl - 1; i >= 0; i--) bitq.push_back(c[i]);
        for (int i = n - 1; i >= 0; i--) bitq.push_back(v[i]);
        model_extract();
    endtask

    task automatic model_flush();
        while ((bitq.size() % 8) != 0) bitq.push_back(1'b1);
        model_extract();
    endtask

    task automatic model_reset();
        bitq.delete();
        expq.delete();
        gotq.delete();
        model_cnt = 0;
    endtask

    task automatic send_sym(input logic [15:0] c, input logic [3:0] hl, input logic [7:0] v, input logic [3:0] vl);
        int n;
        n = 0;
        huff_code = c;
        huff_len  = hl;
        val_bits  = v;
        val_len   = vl;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
        else model_push(c, int'(hl), v, int'(vl));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        model_flush();
    endtask

    task automatic wait_flush_done(input string tag);
        int n;
        int start;
        n = 0;
        start = fd_cnt;
        while (fd_cnt == start && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, (fd_cnt != start)}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, gotq.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            check(tag, {24'd0, gq(i)}, {24'd0, expq[i]});
        end
        gotq.delete();
        expq.delete();
    endtask

    initial begin
        int fd0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        huff_code = 16'd0;
        huff_len  = 4'd0;
        val_bits  = 8'd0;
        val_len   = 4'd0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'h00);
        check("rst_flush_done", {31'd0, flush_done}, 32'd0);
        check("rst_byte_count", {16'd0, byte_count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Two symbols then flush: 0x57, 0x5F
        gotq.delete();
        fd0 = fd_cnt;
        send_sym(16'h0002, 4'd3, 8'h0B, 4'd4);
        send_sym(16'h000A, 4'd4, 8'h00, 4'd0);
        flush_pulse();
        wait_flush_done("seq1_flush_done");
        repeat (3) @(negedge clk);
        check("seq1_nbytes", gotq.size(), 32'd2);
        check("seq1_byte0", {24'd0, gq(0)}, 32'h57);
        check("seq1_byte1", {24'd0, gq(1)}, 32'h5F);
        check("seq1_fd_once", fd_cnt - fd0, 32'd1);
        check("seq1_byte_count", {16'd0, byte_count}, 32'd2);
        gotq.delete();
        expq.delete();
        @(posedge clk);
        #1;

        // ZRL then flush
        send_sym(16'h07F9, 4'd11, 8'h00, 4'd0);
        flush_pulse();
        wait_flush_done("zrl_flush_done");
        repeat (2) @(negedge clk);
        check("zrl_byte0", {24'd0, gq(0)}, 32'hFF);
`ifdef JPEG_BYTE_STUFF_EN
        check("zrl_nbytes", gotq.size(), 32'd3);
        check("zrl_byte1", {24'd0, gq(1)}, 32'h00);
        check("zrl_byte2", {24'd0, gq(2)}, 32'h3F);
        check("zrl_byte_count", {16'd0, byte_count}, 32'd5);
`else
        check("zrl_nbytes", gotq.size(), 32'd2);
        check("zrl_byte1", {24'd0, gq(1)}, 32'h3F);
        check("zrl_byte_count", {16'd0, byte_count}, 32'd4);
`endif
        gotq.delete();
        expq.delete();
        @(posedge clk);
        #1;

        // Backpressure: 16 bits -> 0xAB, 0xC5
        out_ready = 1'b0;
        send_sym(16'h0ABC, 4'd12, 8'h05, 4'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_data", {24'd0, out_data}, 32'hAB);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_pop0_valid", {31'd0, out_valid}, 32'd1);
        check("bp_pop0_data", {24'd0, out_data}, 32'hAB);
        @(negedge clk);
        check("bp_pop1_valid", {31'd0, out_valid}, 32'd1);
        check("bp_pop1_data", {24'd0, out_data}, 32'hC5);
        @(negedge clk);
        check("bp_empty_valid", {31'd0, out_valid}, 32'd0);
        check("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
        check("bp_nbytes", gotq.size(), 32'd2);
        check("bp_byte_count", {16'd0, byte_count}, 32'(model_cnt));
        gotq.delete();
        expq.delete();
        @(posedge clk);
        #1;

        // Empty flush: no bytes, flush_done two cycles after the pulse
        fd0 = fd_cnt;
        flush = 1'b1;
        @(negedge clk);
        check("ef_valid0", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("ef_fd_c1", {31'd0, flush_done}, 32'd0);
        check("ef_valid1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("ef_fd_c2", {31'd0, flush_done}, 32'd1);
        check("ef_valid2", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("ef_fd_c3", {31'd0, flush_done}, 32'd0);
        check("ef_fd_once", fd_cnt - fd0, 32'd1);
        @(posedge clk);
        #1;

        // Reset mid-drain: 0xB4 popped, 0xBF pending in drain
        out_ready = 1'b0;
        send_sym(16'h05A5, 4'd11, 8'h00, 4'd0);
        flush_pulse();
        @(negedge clk);
        check("md_first_data", {24'd0, out_data}, 32'hB4);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("md_drain_valid", {31'd0, out_valid}, 32'd1);
        check("md_drain_data", {24'd0, out_data}, 32'hBF);
        #1;
        rst = 1'b1;
        #1;
        check("md_rst_valid", {31'd0, out_valid}, 32'd0);
        check("md_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("md_rst_byte_count", {16'd0, byte_count}, 32'd0);
        check("md_rst_data", {24'd0, out_data}, 32'h00);
        model_reset();
        fd0 = fd_cnt;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("md_no_flush_done", fd_cnt - fd0, 32'd0);
        check("md_idle_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Randomized symbols with random backpressure, flushed in batches
        rnd_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            int ns;
            ns = $urandom_range(1, 20);
            for (int s = 0; s < ns; s++) begin
                logic [15:0] c;
                c = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
                send_sym(c, 4'($urandom), 8'($urandom), 4'($urandom));
            end
            flush_pulse();
            wait_flush_done("rnd_flush_done");
            compare_stream("rnd_byte");
            check("rnd_byte_count", {16'd0, byte_count}, {16'd0, 16'(model_cnt)});
        end
        rnd_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("end_idle_valid", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
